// File: rtl/flag_unit_if.sv
// Flag unit bus: ALU flag updates, stack push/pop and the condition request/result handshake.
// master drives the requests; slave is the flag_unit side.
interface flag_unit_if;
  logic       alu_valid;
  logic       alu_z;
  logic       alu_n;
  logic       alu_c;
  logic       alu_v;
  logic [3:0] flag_we_mask;
  logic [3:0] flags;
  logic       push;
  logic       pop;
  logic       stack_full;
  logic       stack_empty;
  logic       stack_err;
  logic       cond_valid;
  logic [3:0] cond_code;
  logic       cond_ready;
  logic       res_valid;
  logic       res_taken;
  logic       res_ready;
  logic       ovf_sticky;

  modport master (
    output alu_valid, alu_z, alu_n, alu_c, alu_v, flag_we_mask,
    output push, pop, cond_valid, cond_code, res_ready,
    input  flags, stack_full, stack_empty, stack_err,
    input  cond_ready, res_valid, res_taken, ovf_sticky
  );

  modport slave (
    input  alu_valid, alu_z, alu_n, alu_c, alu_v, flag_we_mask,
    input  push, pop, cond_valid, cond_code, res_ready,
    output flags, stack_full, stack_empty, stack_err,
    output cond_ready, res_valid, res_taken, ovf_sticky
  );
endinterface

// File: rtl/flag_unit.sv
// Status flag register {Z,N,C,V} with masked ALU writes, a save/restore stack and a
// one-entry branch-condition result register. Optional sticky overflow: FLAG_UNIT_OVF_STICKY_EN.
module flag_unit #(
  parameter int STACK_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  flag_unit_if.slave    bus
);

  localparam int PW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [PW:0]   ptr;
  logic [3:0]    stack_mem [STACK_DEPTH];
  logic [3:0]    flags_q;
  logic [3:0]    flags_next;
  logic [3:0]    alu_word;
  logic [3:0]    merged;
  logic [3:0]    eff_flags;
  logic [3:0]    top;
  logic [PW-1:0] top_idx;
  logic          full;
  logic          empty;
  logic          push_only;
  logic          pop_only;
  logic          push_ok;
  logic          pop_ok;
  logic          op_err;
  logic          err_q;
  logic          res_valid_q;
  logic          res_taken_q;
  logic          accept;

  function automatic logic cond_eval(input logic [3:0] code, input logic [3:0] f);
    logic z, n, c, v;
    {z, n, c, v} = f;
    case (code)
      4'd0:    cond_eval = z;
      4'd1:    cond_eval = !z;
      4'd2:    cond_eval = c;
      4'd3:    cond_eval = !c;
      4'd4:    cond_eval = n;
      4'd5:    cond_eval = !n;
      4'd6:    cond_eval = v;
      4'd7:    cond_eval = !v;
      4'd8:    cond_eval = c & !z;
      4'd9:    cond_eval = !c | z;
      4'd10:   cond_eval = (n == v);
      4'd11:   cond_eval = (n != v);
      4'd12:   cond_eval = !z & (n == v);
      4'd13:   cond_eval = z | (n != v);
      4'd14:   cond_eval = 1'b1;
      default: cond_eval = 1'b0;
    endcase
  endfunction

  assign full      = (ptr == (PW+1)'(STACK_DEPTH));
  assign empty     = (ptr == '0);
  assign alu_word  = {bus.alu_z, bus.alu_n, bus.alu_c, bus.alu_v};
  assign merged    = (bus.flag_we_mask & alu_word) | (~bus.flag_we_mask & flags_q);
  assign eff_flags = bus.alu_valid ? merged : flags_q;
  assign top_idx   = PW'(ptr - 1'b1);
  assign top       = stack_mem[top_idx];

  // Push and pop together cancel each other and also swallow the ALU write.
  assign push_only = bus.push & !bus.pop;
  assign pop_only  = bus.pop & !bus.push;
  assign push_ok   = push_only & !full;
  assign pop_ok    = pop_only & !empty;
  assign op_err    = (push_only & full) | (pop_only & empty);

  always_comb begin
    flags_next = flags_q;
    if (pop_ok)
      flags_next = top;
    else if (!bus.pop && !op_err && bus.alu_valid)
      flags_next = merged;
  end

  assign accept         = bus.cond_valid & bus.cond_ready;
  assign bus.cond_ready = !res_valid_q | bus.res_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q     <= '0;
      ptr         <= '0;
      err_q       <= 1'b0;
      res_valid_q <= 1'b0;
      res_taken_q <= 1'b0;
    end else begin
      flags_q <= flags_next;
      if (push_ok)
        ptr <= ptr + 1'b1;
      else if (pop_ok)
        ptr <= ptr - 1'b1;
      if (op_err)
        err_q <= 1'b1;
      if (accept) begin
        res_valid_q <= 1'b1;
        res_taken_q <= cond_eval(bus.cond_code, eff_flags);
      end else if (bus.res_ready) begin
        res_valid_q <= 1'b0;
      end
    end
  end

  // Stack storage needs no reset; the pointer alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (push_ok)
      stack_mem[ptr[PW-1:0]] <= flags_q;
  end

`ifdef FLAG_UNIT_OVF_STICKY_EN
  logic ovf_q;
  logic v_set;

  assign v_set = flags_next[0] &
                 (pop_ok | (bus.alu_valid & !bus.pop & !op_err & bus.flag_we_mask[0]));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ovf_q <= 1'b0;
    else if (v_set)
      ovf_q <= 1'b1;
  end

  assign bus.ovf_sticky = ovf_q;
`else
  assign bus.ovf_sticky = 1'b0;
`endif

  assign bus.flags       = flags_q;
  assign bus.stack_full  = full;
  assign bus.stack_empty = empty;
  assign bus.stack_err   = err_q;
  assign bus.res_valid   = res_valid_q;
  assign bus.res_taken   = res_taken_q;

endmodule

// File: doc/flag_unit.md
Name: flag_unit

Overview:
- Consumer end of the ALU flag interface. Each ALU slice produces Z/N/C/V flags; this block receives them.
- Latches the flags into the processor status register under a per-flag write mask.
- Saves and restores the flags on a small stack for interrupt entry and return.
- Evaluates 4-bit branch condition codes against the current flags. Requests and results use a valid/ready handshake.
- Sits between the ALU flag outputs and the control unit's branch logic.

Parameters:
- STACK_DEPTH, 4, number of 4-bit flag entries in the save/restore stack (power of two, at least 2).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active-high
- alu_valid  in  1  ALU flag update strobe
- alu_z  in  1  ALU zero flag
- alu_n  in  1  ALU negative flag
- alu_c  in  1  ALU carry flag
- alu_v  in  1  ALU overflow flag
- flag_we_mask  in  4  per-flag write enable, bit order {Z,N,C,V} = [3:0]
- flags  out  4  current status register {Z,N,C,V}
- push  in  1  save the current flags to the stack
- pop  in  1  restore the flags from the stack
- stack_full  out  1  stack holds STACK_DEPTH entries
- stack_empty  out  1  stack holds 0 entries
- stack_err  out  1  sticky error: push when full or pop when empty
- cond_valid  in  1  condition request valid
- cond_code  in  4  condition code
- cond_ready  out  1  request accepted this cycle when high together with cond_valid
- res_valid  out  1  result valid
- res_taken  out  1  condition result
- res_ready  in  1  downstream accepts the result
- ovf_sticky  out  1  sticky overflow (optional feature only)

Behaviour:
- Reset is asynchronous, active-high, asserted at any time, including mid-handshake. On reset:
  - flags=0, stack emptied (stack_empty=1, stack_full=0), stack_err=0.
  - res_valid=0, res_taken=0, ovf_sticky=0.
  - Any in-flight result is discarded.
- Flag write: on a clock edge with alu_valid=1, each flag whose mask bit is 1 loads its ALU value; masked-off flags hold. alu_valid=0 means no change.
- Push: copies the flags as they were before this edge onto the stack. A simultaneous ALU write still updates the flags.
- Pop: loads flags from the top of the stack and pops the entry. Pop overrides any ALU write in the same cycle; that ALU write is lost.
- Push and pop in the same cycle: the stack is unchanged and the flags are unchanged, i.e. the ALU write is also lost.
- Push when full or pop when empty: the operation is ignored, stack contents, pointer and flags are unchanged, and stack_err is set. stack_err clears only on reset.
- Condition evaluation uses the effective flags: the ALU-bypassed values when alu_valid=1 in the same cycle (masked bits new, others old), otherwise the register. A pop in the same cycle is not bypassed; the pre-pop flags are used.
- Condition codes:
  - 0 EQ: Z
  - 1 NE: !Z
  - 2 CS: C
  - 3 CC: !C
  - 4 MI: N
  - 5 PL: !N
  - 6 VS: V
  - 7 VC: !V
  - 8 HI: C&!Z
  - 9 LS: !C|Z
  - 10 GE: N==V
  - 11 LT: N!=V
  - 12 GT: !Z&(N==V)
  - 13 LE: Z|(N!=V)
  - 14 AL: 1
  - 15 NV: 0
- Handshake:
  - The result register holds one entry. cond_ready = !res_valid | res_ready (combinational).
  - On accept (cond_valid & cond_ready), res_valid=1 and res_taken is registered on the next edge. Latency is 1 cycle.
  - res_valid falls only on res_ready with no new accept. Back-to-back throughput is 1 per cycle when res_ready stays high.
  - res_taken is stable while res_valid=1 and res_ready=0.
- Stack pointer: counts 0..STACK_DEPTH. stack_full = (ptr==STACK_DEPTH), stack_empty = (ptr==0). Both are registered-derived.

Optional Feature:
- Macro: FLAG_UNIT_OVF_STICKY_EN.
- Defined: ovf_sticky sets on any edge where the V flag register is written with 1, by an ALU write or by a pop. It clears only on reset. It is not pushed and not popped.
- Undefined: ovf_sticky is tied 0 and no register is inferred.

Test Plan:
- Reset mid-run: flags=4'b1111, 2 entries pushed, res_valid=1, then rst pulsed asynchronously between edges -> flags=0, stack_empty=1, res_valid=0 immediately, without waiting for an edge.
- Masked write: flags=0, alu_valid=1, {z,n,c,v}=1111, mask=4'b1010 -> flags=4'b1010. Same cycle cond_valid with code 0 (EQ) -> res_taken=1 one cycle later (bypass).
- Stack: push 4'b0110 with STACK_DEPTH=4, repeat to full, 5th push -> stack_err=1, stack_full=1, contents intact. Pop 4x -> flags restored LIFO. 5th pop -> flags unchanged, stack_empty=1.
- Pop vs ALU: stack top=4'b0001, flags=0, pop and alu_valid=1 with 1111/mask 1111 same cycle -> flags=4'b0001.
- Backpressure: res_ready=0, issue GT with Z=0, N=1, V=1 -> res_valid=1, res_taken=1, cond_ready=0, held for 3 cycles. Then res_ready=1 with a new LT request -> result updates next cycle to 0, no gap.
- Sticky (macro defined): ALU write V=1 then V=0 -> ovf_sticky stays 1 until rst. Macro undefined -> ovf_sticky=0 throughout.
